wb_port_arbiter: RTL and testbench

Shares the single register-file write port between the in-order pipeline writeback (from the MEM/WB stage registers) and out-of-band completions from long-latency units such as a multi-cycle multiply/divide unit or a load-miss return. Pipeline writeback normally has priority. Auxiliary completions are buffered in a small FIFO, and a starvation counter forces a one-cycle pipeline stall so that the FIFO always drains. The block sits between the MEM/WB pipeline registers, the auxiliary units and the register file.

---
 rtl/wb_port_arbiter.sv | 216 +++++++++++++++++++++
 tb/tb_wb_port_arbiter.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: shares the register-file write port between MEM/WB
// writeback and buffered out-of-band completions from long-latency units.
// The pipeline has priority. A starvation counter forces a one-cycle stall
// so that the auxiliary FIFO always drains.
// Optional feature: define WB_ARB_BYPASS_EN to let an aux completion write
// in the same cycle when the FIFO is empty, the pipeline is idle and the
// arbiter is in PIPE_PRI.
module wb_port_arbiter #(
  parameter int XLEN         = 64,
  parameter int AUX_DEPTH    = 4,
  parameter int STARVE_LIMIT = 3
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         pipe_reg_write,
  input  logic [4:0]                   pipe_rd,
  input  logic [XLEN-1:0]              pipe_wdata,
  input  logic                         aux_valid,
  output logic                         aux_ready,
  input  logic [4:0]                   aux_rd,
  input  logic [XLEN-1:0]              aux_wdata,
  output logic                         rf_we,
  output logic [4:0]                   rf_waddr,
  output logic [XLEN-1:0]              rf_wdata,
  output logic                         pipe_stall,
  output logic [$clog2(AUX_DEPTH):0]   aux_count
);

  localparam int PW = $clog2(AUX_DEPTH);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  typedef enum logic [0:0] {
    ST_PIPE_PRI  = 1'b0,
    ST_AUX_FORCE = 1'b1
  } state_e;

  // Registered state
  state_e            state_q, state_d;
  logic [PW:0]       wptr_q, wptr_d;
  logic [PW:0]       rptr_q, rptr_d;
  logic [SW-1:0]     starve_q, starve_d;
  logic [4:0]        mem_rd_q   [AUX_DEPTH];
  logic [4:0]        mem_rd_d   [AUX_DEPTH];
  logic [XLEN-1:0]   mem_data_q [AUX_DEPTH];
  logic [XLEN-1:0]   mem_data_d [AUX_DEPTH];

  // Combinational helpers
  logic              empty_s;
  logic              full_s;
  logic [4:0]        head_rd_s;
  logic [XLEN-1:0]   head_data_s;
  logic              pipe_live_s;
  logic              pipe_grant_s;
  logic              deq_s;
  logic              bypass_s;
  logic              enq_s;

  // FIFO status and head entry; the extra pointer bit tells full from empty
  always_comb begin
    empty_s     = (wptr_q == rptr_q);
    full_s      = (wptr_q[PW] != rptr_q[PW]) &&
                  (wptr_q[PW-1:0] == rptr_q[PW-1:0]);
    head_rd_s   = mem_rd_q[rptr_q[PW-1:0]];
    head_data_s = mem_data_q[rptr_q[PW-1:0]];
    pipe_live_s = pipe_reg_write && (pipe_rd != 5'd0);
  end

  // State register: FSM state, synchronous reset to PIPE_PRI
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_PIPE_PRI;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: force an aux slot once the pipeline has starved the FIFO
  always_comb begin
    state_d = ST_PIPE_PRI;
    case (state_q)
      ST_PIPE_PRI: begin
        if (starve_d >= STARVE_MAX) begin
          state_d = ST_AUX_FORCE;
        end else begin
          state_d = ST_PIPE_PRI;
        end
      end
      ST_AUX_FORCE: begin
        state_d = ST_PIPE_PRI;
      end
      default: begin
        state_d = ST_PIPE_PRI;
      end
    endcase
  end

  // Output logic: choose the write-port owner and drive the register file
  always_comb begin
    rf_we        = 1'b0;
    rf_waddr     = 5'd0;
    rf_wdata     = {XLEN{1'b0}};
    pipe_stall   = 1'b0;
    aux_ready    = 1'b0;
    deq_s        = 1'b0;
    pipe_grant_s = 1'b0;
    bypass_s     = 1'b0;
    if (reset) begin
      rf_we = 1'b0;
    end else begin
      aux_ready = !full_s;
      case (state_q)
        ST_AUX_FORCE: begin
          // Head wins unconditionally; the pipeline re-presents next cycle
          pipe_stall = 1'b1;
          deq_s      = 1'b1;
          rf_we      = (head_rd_s != 5'd0);
          rf_waddr   = head_rd_s;
          rf_wdata   = head_data_s;
        end
        ST_PIPE_PRI: begin
          if (pipe_live_s) begin
            pipe_grant_s = 1'b1;
            rf_we        = 1'b1;
            rf_waddr     = pipe_rd;
            rf_wdata     = pipe_wdata;
          end else if (!empty_s) begin
            // rd=0 entries still consume their slot with the write suppressed
            deq_s    = 1'b1;
            rf_we    = (head_rd_s != 5'd0);
            rf_waddr = head_rd_s;
            rf_wdata = head_data_s;
          end else begin
`ifdef WB_ARB_BYPASS_EN
            if (aux_valid) begin
              bypass_s = 1'b1;
              rf_we    = (aux_rd != 5'd0);
              rf_waddr = aux_rd;
              rf_wdata = aux_wdata;
            end else begin
              bypass_s = 1'b0;
            end
`else
            bypass_s = 1'b0;
`endif
          end
        end
        default: begin
          rf_we = 1'b0;
        end
      endcase
    end
  end

  // Enqueue unless the completion was written straight through
  always_comb begin
    enq_s = aux_valid && aux_ready && !bypass_s;
  end

  // Starvation counter: counts pipeline wins while the FIFO waits
  always_comb begin
    if ((state_q == ST_PIPE_PRI) && pipe_grant_s && !empty_s) begin
      starve_d = starve_q + SW'(1);
    end else begin
      starve_d = {SW{1'b0}};
    end
  end

  // Pointer advance for enqueue and dequeue
  always_comb begin
    wptr_d = wptr_q + {{PW{1'b0}}, enq_s};
    rptr_d = rptr_q + {{PW{1'b0}}, deq_s};
  end

  // FIFO storage write at the tail
  always_comb begin
    mem_rd_d   = mem_rd_q;
    mem_data_d = mem_data_q;
    if (enq_s) begin
      mem_rd_d[wptr_q[PW-1:0]]   = aux_rd;
      mem_data_d[wptr_q[PW-1:0]] = aux_wdata;
    end else begin
      mem_rd_d   = mem_rd_q;
      mem_data_d = mem_data_q;
    end
  end

  // Pointer, counter and storage registers; reset discards queued entries
  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q   <= {(PW+1){1'b0}};
      rptr_q   <= {(PW+1){1'b0}};
      starve_q <= {SW{1'b0}};
      for (int i = 0; i < AUX_DEPTH; i++) begin
        mem_rd_q[i]   <= 5'd0;
        mem_data_q[i] <= {XLEN{1'b0}};
      end
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      starve_q   <= starve_d;
      mem_rd_q   <= mem_rd_d;
      mem_data_q <= mem_data_d;
    end
  end

  // Occupancy reads zero while reset is held
  always_comb begin
    if (reset) begin
      aux_count = {(PW+1){1'b0}};
    end else begin
      aux_count = wptr_q - rptr_q;
    end
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Self-checking bench for wb_port_arbiter: directed steps followed by a
// randomized phase, compared every cycle against a queue-based model.
module tb_wb_port_arbiter;
  localparam int XLEN  = 64;
  localparam int DEPTH = 4;
  localparam int LIMIT = 3;
`ifdef WB_ARB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            reset;
  logic            pipe_reg_write;
  logic [4:0]      pipe_rd;
  logic [XLEN-1:0] pipe_wdata;
  logic            aux_valid;
  logic            aux_ready;
  logic [4:0]      aux_rd;
  logic [XLEN-1:0] aux_wdata;
  logic            rf_we;
  logic [4:0]      rf_waddr;
  logic [XLEN-1:0] rf_wdata;
  logic            pipe_stall;
  logic [2:0]      aux_count;

  wb_port_arbiter #(.XLEN(XLEN), .AUX_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .reset(reset),
    .pipe_reg_write(pipe_reg_write), .pipe_rd(pipe_rd), .pipe_wdata(pipe_wdata),
    .aux_valid(aux_valid), .aux_ready(aux_ready), .aux_rd(aux_rd), .aux_wdata(aux_wdata),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .pipe_stall(pipe_stall), .aux_count(aux_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0]  rd;
    logic [63:0] data;
  } ent_t;

  ent_t mq[$];
  int   m_starve;
  bit   m_force;
  int   pass_cnt;
  int   total_cnt;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step(input logic pwe, input logic [4:0] prd, input logic [63:0] pdat,
                      input logic av, input logic [4:0] ard, input logic [63:0] adat);
    bit        e_we, e_stall, e_ready, byp, live;
    logic [4:0]  e_addr;
    logic [63:0] e_data;
    ent_t      h;
    reset = 1'b0;
    pipe_reg_write = pwe; pipe_rd = prd; pipe_wdata = pdat;
    aux_valid = av; aux_rd = ard; aux_wdata = adat;
    @(negedge clk);
    e_we = 1'b0; e_stall = 1'b0; byp = 1'b0; e_addr = 5'd0; e_data = 64'd0;
    e_ready = (mq.size() < DEPTH);
    live = pwe && (prd != 5'd0);
    check("aux_count", 64'(aux_count), 64'(mq.size()));
    if (m_force) begin
      h = mq.pop_front();
      e_stall = 1'b1; e_we = (h.rd != 5'd0); e_addr = h.rd; e_data = h.data;
      m_starve = 0;
    end else if (live) begin
      e_we = 1'b1; e_addr = prd; e_data = pdat;
      m_starve = (mq.size() > 0) ? m_starve + 1 : 0;
    end else if (mq.size() > 0) begin
      h = mq.pop_front();
      e_we = (h.rd != 5'd0); e_addr = h.rd; e_data = h.data;
      m_starve = 0;
    end else if (BYP && av) begin
      byp = 1'b1; e_we = (ard != 5'd0); e_addr = ard; e_data = adat;
      m_starve = 0;
    end else begin
      m_starve = 0;
    end
    m_force = (m_starve == LIMIT);
    if (av && e_ready && !byp) mq.push_back('{rd: ard, data: adat});
    check("rf_we", 64'(rf_we), 64'(e_we));
    check("pipe_stall", 64'(pipe_stall), 64'(e_stall));
    check("aux_ready", 64'(aux_ready), 64'(e_ready));
    if (e_we) begin
      check("rf_waddr", 64'(rf_waddr), 64'(e_addr));
      check("rf_wdata", rf_wdata, e_data);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic reset_cycle(input logic pwe, input logic av);
    reset = 1'b1;
    pipe_reg_write = pwe; pipe_rd = 5'd5; pipe_wdata = 64'h1234;
    aux_valid = av; aux_rd = 5'd7; aux_wdata = 64'hAA;
    @(negedge clk);
    check("rst_rf_we", 64'(rf_we), 64'd0);
    check("rst_aux_ready", 64'(aux_ready), 64'd0);
    check("rst_pipe_stall", 64'(pipe_stall), 64'd0);
    check("rst_rf_waddr", 64'(rf_waddr), 64'd0);
    check("rst_rf_wdata", rf_wdata, 64'd0);
    check("rst_aux_count", 64'(aux_count), 64'd0);
    mq.delete(); m_starve = 0; m_force = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    pass_cnt = 0; total_cnt = 0; m_starve = 0; m_force = 1'b0;
    reset = 1'b1; pipe_reg_write = 1'b1; pipe_rd = 5'd5; pipe_wdata = 64'h1234;
    aux_valid = 1'b1; aux_rd = 5'd7; aux_wdata = 64'hAA;

    // Reset with both sources active, then pipeline write right after
    reset_cycle(1'b1, 1'b1);
    reset_cycle(1'b1, 1'b1);
    step(1'b1, 5'd5, 64'h1234, 1'b0, 5'd0, 64'd0);

    // Starvation: x5 every cycle, x7=0xAA pushed once
    step(1'b1, 5'd5, 64'h1234, 1'b1, 5'd7, 64'hAA);
    for (int i = 0; i < 5; i++) step(1'b1, 5'd5, 64'h1234, 1'b0, 5'd0, 64'd0);

    // Fill to full while pipeline is live, then drain with the pipeline idle
    for (int i = 0; i < 6; i++)
      step(1'b1, 5'd6, 64'h600 + 64'(i), 1'b1, 5'(i + 1), 64'h100 + 64'(i));
    for (int i = 0; i < 6; i++) step(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0);

    // Back-to-back pushes with the pipeline idle
    for (int i = 0; i < DEPTH; i++)
      step(1'b0, 5'd0, 64'd0, 1'b1, 5'(10 + i), 64'h200 + 64'(i));
    for (int i = 0; i < 3; i++) step(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0);

    // rd=0 entry queued behind a live pipeline, then consumed silently
    step(1'b1, 5'd4, 64'h44, 1'b1, 5'd0, 64'hFF);
    step(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0);
    step(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0);

    // Pipeline rd=0 write while the FIFO holds x3
    step(1'b1, 5'd4, 64'h44, 1'b1, 5'd3, 64'h33);
    step(1'b1, 5'd0, 64'hDEAD, 1'b0, 5'd0, 64'd0);
    step(1'b1, 5'd4, 64'h45, 1'b0, 5'd0, 64'd0);

    // Empty FIFO, idle pipeline, aux x9=0x55
    step(1'b0, 5'd0, 64'd0, 1'b1, 5'd9, 64'h55);
    step(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0);

    // Reset mid-drain discards queued entries
    for (int i = 0; i < 3; i++)
      step(1'b1, 5'd8, 64'h800, 1'b1, 5'(20 + i), 64'h300 + 64'(i));
    reset_cycle(1'b0, 1'b1);
    for (int i = 0; i < 2; i++) step(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 63) == 0) begin
        reset_cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end else begin
        step(1'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 31)),
             {$urandom(), $urandom()},
             1'($urandom_range(0, 2) == 0), 5'($urandom_range(0, 31)),
             {$urandom(), $urandom()});
      end
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
